trap_sequencer: RTL
===================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath/CSR width.
REQ-002 SHALL have parameter FLUSH_TIMEOUT, default 15: maximum cycles spent waiting for flush_ack.
REQ-003 SHALL have port clk  in  1: single clock, rising edge; the block has one clock.
REQ-004 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-005 SHALL have port cur_priv  in  priv_e: current privilege level.
REQ-006 SHALL have ports sstatus_q, sie_q, sip_q, stvec_q, sepc_q  in  XLEN each: CSR state.
REQ-007 SHALL have ports time_value, stimecmp_q  in  XLEN each: timer value and compare value.
REQ-008 SHALL have port ext_irq  in  1: level-sensitive external interrupt.
REQ-009 SHALL have ports exc_valid  in  1, exc_cause  in  5, exc_pc  in  XLEN, exc_tval  in  XLEN: synchronous exception report.
REQ-010 SHALL have port irq_pc  in  XLEN: PC of the next unretired instruction.
REQ-011 SHALL have port sret_req  in  1: SRET retiring.
REQ-012 SHALL have ports flush_req  out  1 and flush_ack  in  1: pipeline drain handshake.
REQ-013 SHALL have ports trap_set  out  1, trap_is_irq  out  1, trap_scause  out  XLEN, trap_sepc  out  XLEN, trap_stval  out  XLEN: trap writes to the CSR file.
REQ-014 SHALL have ports do_sret  out  1 and next_priv  out  priv_e: return commit.
REQ-015 SHALL have ports redirect_valid  out  1, redirect_pc  out  XLEN, busy  out  1, flush_timeout_err  out  1.

Function
REQ-016 SHALL compute pend = sip_q | (time_value>=stimecmp_q, unsigned, at bit 5) | (ext_irq at bit 9), then masked = pend & sie_q.
REQ-017 SHALL treat interrupts as globally enabled iff cur_priv==PRIV_U, or cur_priv==PRIV_S with sstatus_q[1]=1; in PRIV_M they SHALL be disabled.
REQ-018 SHALL resolve priority as: exc_valid > SEI(9) > SSI(1) > STI(5) > sret_req, with only the winner accepted.
REQ-019 SHALL sample sources only in IDLE; while busy=1, all sources SHALL be ignored and not queued.
REQ-020 SHALL latch cause, epc and tval on acceptance: exception -> {0,exc_cause}, exc_pc, exc_tval; interrupt -> {1,code}, irq_pc, 0.
REQ-021 SHALL implement states IDLE, FLUSH, COMMIT, REDIRECT, RET_FLUSH, RET_COMMIT.
REQ-022 SHALL transition IDLE -> FLUSH on a trap, and IDLE -> RET_FLUSH on sret.
REQ-023 SHALL hold flush_req=1 in FLUSH and RET_FLUSH until flush_ack is sampled 1; on that edge it SHALL advance to COMMIT or RET_COMMIT respectively.
REQ-024 SHALL, in COMMIT, pulse trap_set=1 for exactly 1 cycle, with trap_* equal to the latched values and trap_is_irq=cause[XLEN-1]; it SHALL then go to REDIRECT.
REQ-025 SHALL, in REDIRECT, pulse redirect_valid=1 for 1 cycle with redirect_pc=stvec_q & ~3, then return to IDLE.
REQ-026 SHALL, in RET_COMMIT, pulse do_sret=1 and redirect_valid=1 for 1 cycle with redirect_pc=sepc_q and next_priv = sstatus_q[8] ? PRIV_S : PRIV_U, then return to IDLE.
REQ-027 SHALL give a minimum trap latency (acceptance to redirect) of 4 cycles when flush_ack arrives in the first FLUSH cycle.
REQ-028 SHALL, if flush_ack is not seen within FLUSH_TIMEOUT cycles, set sticky flush_timeout_err=1 and proceed as if acked; only rst SHALL clear flush_timeout_err.
REQ-029 SHALL, on exc_valid and sret_req together, take the exception; on exc_valid with an enabled interrupt, take the exception; the losing request SHALL be dropped.
REQ-030 SHALL drive busy=1 in every state except IDLE.

Reset
REQ-031 SHALL, with rst=1 at a clock edge, enter IDLE regardless of the current state, including mid-FLUSH.
REQ-032 SHALL reset flush_req, trap_set, trap_is_irq, do_sret, redirect_valid, busy and flush_timeout_err to 0.
REQ-033 SHALL reset trap_scause, trap_sepc, trap_stval and redirect_pc to 0, and next_priv to PRIV_U.

Structure
REQ-034 SHALL source priv_e, the state enum, IRQ bit indices (SSI=1, STI=5, SEI=9) and the cause interrupt-bit constant from the shared harvos package.
REQ-035 SHALL place the pending/enable/priority logic in one sub-module, trap_prio_enc, whose outputs are take_irq and irq_code[4:0].

Verification
REQ-036 SHALL cover: exc_valid, exc_cause=2, exc_pc=0x100, stvec=0x2000, flush_ack one cycle later -> trap_scause=0x2, trap_sepc=0x100, then redirect_pc=0x2000.
REQ-037 SHALL cover: S-mode, SIE=1, sie=0x220, timer elapsed and ext_irq=1 -> scause=0x80000009; in M-mode the same stimulus -> no trap.
REQ-038 SHALL cover: exc_valid and sret_req in the same cycle -> trap taken, do_sret never asserted.
REQ-039 SHALL cover: flush_ack held 0 with FLUSH_TIMEOUT=15 -> flush_timeout_err=1 at cycle 15, then COMMIT.
REQ-040 SHALL cover: sret with sepc=0x400, SPP=1 -> do_sret=1, next_priv=PRIV_S, redirect_pc=0x400.
REQ-041 SHALL cover: rst asserted during FLUSH -> IDLE next cycle, all outputs 0, no trap_set.

Source files
------------

// File: rtl/harvos_pkg.sv
// Shared definitions for the trap path: privilege levels, trap sequencer
// states, interrupt bit positions and the CSR field positions it reads.
package harvos_pkg;

   typedef enum logic [1:0] {
      PRIV_U = 2'b00,
      PRIV_S = 2'b01,
      PRIV_M = 2'b11
   } priv_e;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FLUSH      = 3'd1,
      ST_COMMIT     = 3'd2,
      ST_REDIRECT   = 3'd3,
      ST_RET_FLUSH  = 3'd4,
      ST_RET_COMMIT = 3'd5
   } trap_state_e;

   // Supervisor interrupt bit positions in sip/sie (also the cause codes)
   localparam int IRQ_SSI = 1;
   localparam int IRQ_STI = 5;
   localparam int IRQ_SEI = 9;

   // sstatus field positions
   localparam int SSTATUS_SIE = 1;
   localparam int SSTATUS_SPP = 8;

   // Value of the scause MSB for an interrupt (0 for an exception)
   localparam logic CAUSE_INTR = 1'b1;

endpackage

// File: rtl/trap_sequencer_prio_enc.sv
// Supervisor interrupt pending/enable evaluation and fixed-priority pick.
// Pending = sip | timer-elapsed (STI) | external line (SEI), masked by sie,
// gated by the global enable derived from the current privilege.
module trap_prio_enc
   import harvos_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  priv_e            cur_priv,
   input  logic [XLEN-1:0]  sstatus_q,
   input  logic [XLEN-1:0]  sie_q,
   input  logic [XLEN-1:0]  sip_q,
   input  logic [XLEN-1:0]  time_value,
   input  logic [XLEN-1:0]  stimecmp_q,
   input  logic             ext_irq,
   output logic             take_irq,
   output logic [4:0]       irq_code
);

   logic            timer_hit;
   logic            glb_en;
   logic            sei_m;
   logic            ssi_m;
   logic            sti_m;
   logic            unused_bits;

   // Only the three supervisor interrupt bits and sstatus.SIE matter here
   assign unused_bits = ^{sstatus_q, sie_q, sip_q};

   // Pending/enable evaluation and priority SEI > SSI > STI
   always_comb begin
      timer_hit = (time_value >= stimecmp_q);
      glb_en    = (cur_priv == PRIV_U) ||
                  ((cur_priv == PRIV_S) && sstatus_q[SSTATUS_SIE]);
      sei_m     = (sip_q[IRQ_SEI] | ext_irq)   & sie_q[IRQ_SEI];
      ssi_m     =  sip_q[IRQ_SSI]              & sie_q[IRQ_SSI];
      sti_m     = (sip_q[IRQ_STI] | timer_hit) & sie_q[IRQ_STI];
      take_irq  = 1'b0;
      irq_code  = 5'd0;
      if (glb_en) begin
         if (sei_m) begin
            take_irq = 1'b1;
            irq_code = 5'(IRQ_SEI);
         end else if (ssi_m) begin
            take_irq = 1'b1;
            irq_code = 5'(IRQ_SSI);
         end else if (sti_m) begin
            take_irq = 1'b1;
            irq_code = 5'(IRQ_STI);
         end
      end
   end

endmodule

// File: rtl/trap_sequencer.sv
// Supervisor trap/return sequencer. In IDLE it accepts one event (exception,
// interrupt or SRET), drains the pipeline via flush_req/flush_ack (bounded by
// FLUSH_TIMEOUT), then commits the CSR update and redirects fetch.
module trap_sequencer
   import harvos_pkg::*;
#(
   parameter int XLEN          = 32,
   parameter int FLUSH_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  priv_e            cur_priv,
   input  logic [XLEN-1:0]  sstatus_q,
   input  logic [XLEN-1:0]  sie_q,
   input  logic [XLEN-1:0]  sip_q,
   input  logic [XLEN-1:0]  stvec_q,
   input  logic [XLEN-1:0]  sepc_q,
   input  logic [XLEN-1:0]  time_value,
   input  logic [XLEN-1:0]  stimecmp_q,
   input  logic             ext_irq,
   input  logic             exc_valid,
   input  logic [4:0]       exc_cause,
   input  logic [XLEN-1:0]  exc_pc,
   input  logic [XLEN-1:0]  exc_tval,
   input  logic [XLEN-1:0]  irq_pc,
   input  logic             sret_req,
   output logic             flush_req,
   input  logic             flush_ack,
   output logic             trap_set,
   output logic             trap_is_irq,
   output logic [XLEN-1:0]  trap_scause,
   output logic [XLEN-1:0]  trap_sepc,
   output logic [XLEN-1:0]  trap_stval,
   output logic             do_sret,
   output priv_e            next_priv,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             busy,
   output logic             flush_timeout_err
);

   localparam int                CNT_W     = $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(FLUSH_TIMEOUT - 1);

   trap_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   cause_q, cause_d;
   logic [XLEN-1:0]   epc_q, epc_d;
   logic [XLEN-1:0]   tval_q, tval_d;
   logic              err_q, err_d;
   logic              take_irq;
   logic [4:0]        irq_code;

   trap_prio_enc #(
      .XLEN (XLEN)
   ) u_prio (
      .cur_priv   (cur_priv),
      .sstatus_q  (sstatus_q),
      .sie_q      (sie_q),
      .sip_q      (sip_q),
      .time_value (time_value),
      .stimecmp_q (stimecmp_q),
      .ext_irq    (ext_irq),
      .take_irq   (take_irq),
      .irq_code   (irq_code)
   );

   // Latched trap record is presented continuously; trap_set qualifies it
   assign trap_scause       = cause_q;
   assign trap_sepc         = epc_q;
   assign trap_stval        = tval_q;
   assign busy              = (state_q != ST_IDLE);
   assign flush_timeout_err = err_q;

   // Next-state, capture of the accepted event and Moore outputs
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      cause_d        = cause_q;
      epc_d          = epc_q;
      tval_d         = tval_q;
      err_d          = err_q;
      flush_req      = 1'b0;
      trap_set       = 1'b0;
      trap_is_irq    = 1'b0;
      do_sret        = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      next_priv      = PRIV_U;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            // Exception beats interrupts beats SRET; losers are simply dropped
            if (exc_valid) begin
               cause_d = XLEN'(exc_cause);
               epc_d   = exc_pc;
               tval_d  = exc_tval;
               state_d = ST_FLUSH;
            end else if (take_irq) begin
               cause_d            = '0;
               cause_d[4:0]       = irq_code;
               cause_d[XLEN-1]    = CAUSE_INTR;
               epc_d              = irq_pc;
               tval_d             = '0;
               state_d            = ST_FLUSH;
            end else if (sret_req) begin
               state_d = ST_RET_FLUSH;
            end
         end
         ST_FLUSH, ST_RET_FLUSH: begin
            flush_req = 1'b1;
            // A missing ack after the budget is recorded, then treated as acked
            if (flush_ack || (cnt_q == CNT_LIMIT)) begin
               if (!flush_ack) begin
                  err_d = 1'b1;
               end
               cnt_d   = '0;
               state_d = (state_q == ST_FLUSH) ? ST_COMMIT : ST_RET_COMMIT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_COMMIT: begin
            trap_set    = 1'b1;
            trap_is_irq = cause_q[XLEN-1];
            state_d     = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            redirect_valid = 1'b1;
            redirect_pc    = stvec_q & ~XLEN'(3);
            state_d        = ST_IDLE;
         end
         ST_RET_COMMIT: begin
            do_sret        = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = sepc_q;
            next_priv      = sstatus_q[SSTATUS_SPP] ? PRIV_S : PRIV_U;
            state_d        = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, timeout counter, trap record and sticky timeout flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cause_q <= '0;
         epc_q   <= '0;
         tval_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cause_q <= cause_d;
         epc_q   <= epc_d;
         tval_q  <= tval_d;
         err_q   <= err_d;
      end
   end

endmodule
